// File: rtl/serial_frame_sync_pkg.sv
// Shared types and sizing helpers for the serial frame synchroniser.
package frame_sync_pkg;

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    localparam logic [7:0] DEFAULT_SYNC_PATTERN = 8'hA7;

    function automatic int frame_bits(input int sync_w, input int payload_bytes);
        return sync_w + 8 * payload_bytes;
    endfunction

    function automatic int cnt_width(input int n_bits);
        return $clog2(n_bits);
    endfunction

endpackage

// File: rtl/serial_frame_sync_if.sv
// Signal bundle between the descrambled bit source and the frame synchroniser.
// Optional: SYNC_ERR_CNT_EN adds the saturating sync_err_cnt signal.
interface serial_frame_sync_if;
    logic       enable;
    logic       serial_in;
    logic       frame_lock;
    logic       frame_start;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       sync_miss;
`ifdef SYNC_ERR_CNT_EN
    logic [15:0] sync_err_cnt;

    modport master (output enable, serial_in,
                    input  frame_lock, frame_start, byte_out, byte_valid, sync_miss, sync_err_cnt);
    modport slave  (input  enable, serial_in,
                    output frame_lock, frame_start, byte_out, byte_valid, sync_miss, sync_err_cnt);
`else
    modport master (output enable, serial_in,
                    input  frame_lock, frame_start, byte_out, byte_valid, sync_miss);
    modport slave  (input  enable, serial_in,
                    output frame_lock, frame_start, byte_out, byte_valid, sync_miss);
`endif
endinterface

// File: rtl/serial_frame_sync_detector.sv
// Sync-word shift register and comparator; hit reflects the register contents
// after the bit sampled on the current edge, so decisions land on that same edge.
module sync_detector
    import frame_sync_pkg::*;
#(
    parameter int                SYNC_W       = 8,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(DEFAULT_SYNC_PATTERN)
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic serial_in,
    output logic hit
);
    localparam int                FILL_W   = $clog2(SYNC_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_W - 1);

    logic [SYNC_W-1:0] shift_q;
    logic [SYNC_W-1:0] shift_d;
    logic [FILL_W-1:0] fill_q;

    assign shift_d = {shift_q[SYNC_W-2:0], serial_in};
    // A window is only valid once SYNC_W real bits have entered since reset.
    assign hit     = enable && (fill_q == FILL_MAX) && (shift_d == SYNC_PATTERN);

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            fill_q  <= '0;
        end else if (enable) begin
            shift_q <= shift_d;
            if (fill_q != FILL_MAX)
                fill_q <= fill_q + FILL_W'(1);
        end
    end

endmodule

// File: rtl/serial_frame_sync.sv
// Bit-serial frame synchroniser: hunts the sync word, verifies its period, then deframes payload bytes.
// Optional: define SYNC_ERR_CNT_EN to add the saturating sync_err_cnt counter.
module serial_frame_sync
    import frame_sync_pkg::*;
#(
    parameter int                SYNC_W        = 8,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN  = SYNC_W'(DEFAULT_SYNC_PATTERN),
    parameter int                PAYLOAD_BYTES = 4,
    parameter int                LOCK_CNT      = 2,
    parameter int                LOSS_CNT      = 3
) (
    input  logic               clk,
    input  logic               rst,
    serial_frame_sync_if.slave bus
);
    localparam int               FRAME_BITS = frame_bits(SYNC_W, PAYLOAD_BYTES);
    localparam int               CNT_W      = cnt_width(FRAME_BITS);
    localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] PAY_FIRST  = CNT_W'(SYNC_W);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [3:0]       LOCK_TGT   = 4'(LOCK_CNT);
    localparam logic [3:0]       LOSS_TGT   = 4'(LOSS_CNT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]       good_q, good_d, miss_q, miss_d;
    logic [6:0]       byte_sr;
    logic [2:0]       pay_lsb;
    logic             hit, check_pt, byte_done;
    logic             start_d, miss_pulse_d, valid_d;

    sync_detector #(
        .SYNC_W      (SYNC_W),
        .SYNC_PATTERN(SYNC_PATTERN)
    ) u_detector (
        .clk      (clk),
        .rst      (rst),
        .enable   (bus.enable),
        .serial_in(bus.serial_in),
        .hit      (hit)
    );

    // bit_cnt is the position of the bit being sampled; the sync word occupies
    // positions 0..SYNC_W-1 and is judged on its last bit.
    assign pay_lsb   = 3'(bit_cnt_q - PAY_FIRST);
    assign check_pt  = (bit_cnt_q == SYNC_LAST);
    assign byte_done = (bit_cnt_q >= PAY_FIRST) && (&pay_lsb);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        good_d       = good_q;
        miss_d       = miss_q;
        start_d      = 1'b0;
        miss_pulse_d = 1'b0;
        valid_d      = 1'b0;
        if (bus.enable) begin
            bit_cnt_d = (bit_cnt_q == FRAME_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
            unique case (state_q)
                HUNT: begin
                    bit_cnt_d = '0;
                    if (hit) begin
                        state_d   = VERIFY;
                        bit_cnt_d = PAY_FIRST;
                        good_d    = '0;
                    end
                end
                VERIFY: begin
                    if (check_pt) begin
                        if (!hit) begin
                            miss_pulse_d = 1'b1;
                            state_d      = HUNT;
                        end else if (good_q + 4'd1 == LOCK_TGT) begin
                            state_d = LOCKED;
                            start_d = 1'b1;
                            miss_d  = '0;
                        end else begin
                            good_d = good_q + 4'd1;
                        end
                    end
                end
                LOCKED: begin
                    valid_d = byte_done;
                    if (check_pt) begin
                        if (hit) begin
                            miss_d  = '0;
                            start_d = 1'b1;
                        end else begin
                            miss_pulse_d = 1'b1;
                            if (miss_q + 4'd1 == LOSS_TGT) begin
                                state_d = HUNT;
                                miss_d  = '0;
                            end else begin
                                miss_d = miss_q + 4'd1;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= HUNT;
            bit_cnt_q       <= '0;
            good_q          <= '0;
            miss_q          <= '0;
            bus.frame_lock  <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.byte_valid  <= 1'b0;
            bus.sync_miss   <= 1'b0;
            bus.byte_out    <= 8'h00;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            good_q          <= good_d;
            miss_q          <= miss_d;
            bus.frame_lock  <= (state_d == LOCKED);
            bus.frame_start <= start_d;
            bus.byte_valid  <= valid_d;
            bus.sync_miss   <= miss_pulse_d;
            if (valid_d)
                bus.byte_out <= {byte_sr, bus.serial_in};
        end
    end

    // Every byte is rebuilt from eight fresh bits before use, so no reset is needed.
    always_ff @(posedge clk) begin
        if (bus.enable)
            byte_sr <= {byte_sr[5:0], bus.serial_in};
    end

`ifdef SYNC_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_cnt_q <= '0;
        else if (miss_pulse_d && (err_cnt_q != 16'hFFFF))
            err_cnt_q <= err_cnt_q + 16'd1;
    end

    assign bus.sync_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_serial_frame_sync.sv
// Scenario bench for serial_frame_sync: payload bytes are scoreboarded, sync events checked inline.
module tb_serial_frame_sync;

    localparam logic [7:0]  SYNC = 8'hA7;
    localparam logic [7:0]  BAD  = 8'hA6;
    localparam logic [31:0] PAY  = 32'h11223344;

    logic       clk = 1'b0;
    logic       rst;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_bytes[$];
    logic [7:0] mon_exp;
    logic       en_last = 1'b0;

    serial_frame_sync_if bus();

    serial_frame_sync dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) en_last <= bus.enable;

    // Byte scoreboard plus a guard that no pulse appears after a disabled edge.
    always @(negedge clk) begin
        if (bus.byte_valid === 1'b1) begin
            n_checks++;
            if (exp_bytes.size() == 0) begin
                n_fail++;
                $display("FAIL byte_unexpected: byte_out=%h while no byte was due", bus.byte_out);
            end else begin
                mon_exp = exp_bytes.pop_front();
                if (bus.byte_out !== mon_exp) begin
                    n_fail++;
                    $display("FAIL byte_value: byte_out=%h expected %h", bus.byte_out, mon_exp);
                end
            end
        end
        if ((bus.byte_valid === 1'b1) || (bus.frame_start === 1'b1) || (bus.sync_miss === 1'b1)) begin
            n_checks++;
            if (en_last !== 1'b1) begin
                n_fail++;
                $display("FAIL pulse_stretch: valid=%b start=%b miss=%b after disabled edge, expected all 0",
                         bus.byte_valid, bus.frame_start, bus.sync_miss);
            end
        end
    end

    task automatic send_bit(input logic b, input bit gap);
        if (gap) begin
            @(negedge clk);
            bus.enable    = 1'b0;
            bus.serial_in = 1'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        bus.enable    = 1'b1;
        bus.serial_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        for (int i = 7; i >= 0; i--) send_bit(b[i], gap);
    endtask

    task automatic send_payload(input logic [31:0] p, input bit gap, input bit expect_bytes);
        if (expect_bytes)
            for (int i = 3; i >= 0; i--) exp_bytes.push_back(p[8*i +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(p[8*i +: 8], gap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.serial_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic lock_up();
        send_byte(SYNC, 1'b0); send_payload(PAY, 1'b0, 1'b0);
        send_byte(SYNC, 1'b0); send_payload(PAY, 1'b0, 1'b0);
        send_byte(SYNC, 1'b0); send_payload(PAY, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.serial_in = 1'($urandom);
        end
        @(posedge clk);
        #1;
        n_checks++; if (bus.frame_lock !== 1'b0)   begin n_fail++; $display("FAIL rst_lock: got %b expected 0", bus.frame_lock); end
        n_checks++; if (bus.frame_start !== 1'b0)  begin n_fail++; $display("FAIL rst_start: got %b expected 0", bus.frame_start); end
        n_checks++; if (bus.byte_out !== 8'h00)    begin n_fail++; $display("FAIL rst_byte: got %h expected 00", bus.byte_out); end
        n_checks++; if (bus.byte_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bus.byte_valid); end
        n_checks++; if (bus.sync_miss !== 1'b0)    begin n_fail++; $display("FAIL rst_miss: got %b expected 0", bus.sync_miss); end
`ifdef SYNC_ERR_CNT_EN
        n_checks++; if (bus.sync_err_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_errcnt: got %h expected 0000", bus.sync_err_cnt); end
`endif
        @(negedge clk);
        rst        = 1'b0;
        bus.enable = 1'b0;
    endtask

    task automatic test_clean_lock(input bit gap, input string tag);
        do_reset();
        send_byte(SYNC, gap); send_payload(PAY, gap, 1'b0);
        send_byte(SYNC, gap); send_payload(PAY, gap, 1'b0);
        for (int i = 7; i >= 1; i--) send_bit(SYNC[i], gap);
        n_checks++; if (bus.frame_lock !== 1'b0) begin n_fail++; $display("FAIL %s lock_early: got %b expected 0", tag, bus.frame_lock); end
        send_bit(SYNC[0], gap);
        n_checks++; if (bus.frame_lock !== 1'b1)  begin n_fail++; $display("FAIL %s lock_rise: got %b expected 1", tag, bus.frame_lock); end
        n_checks++; if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL %s start_at_lock: got %b expected 1", tag, bus.frame_start); end
        send_payload(PAY, gap, 1'b1);
        send_byte(SYNC, gap);
        n_checks++; if (exp_bytes.size() != 0)    begin n_fail++; $display("FAIL %s bytes_drained: %0d left expected 0", tag, exp_bytes.size()); end
        n_checks++; if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL %s start_locked: got %b expected 1", tag, bus.frame_start); end
        n_checks++; if (bus.byte_out !== 8'h44)   begin n_fail++; $display("FAIL %s byte_hold: got %h expected 44", tag, bus.byte_out); end
    endtask

    task automatic test_false_hit();
        do_reset();
        send_byte(8'h3C, 1'b0); send_byte(8'h00, 1'b0); send_byte(SYNC, 1'b0);
        send_payload(32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
        n_checks++; if (bus.sync_miss !== 1'b0)  begin n_fail++; $display("FAIL fh_miss_early: got %b expected 0", bus.sync_miss); end
        send_bit(1'b0, 1'b0);
        n_checks++; if (bus.sync_miss !== 1'b1)  begin n_fail++; $display("FAIL fh_miss: got %b expected 1", bus.sync_miss); end
        n_checks++; if (bus.frame_lock !== 1'b0) begin n_fail++; $display("FAIL fh_lock: got %b expected 0", bus.frame_lock); end
        send_byte(SYNC, 1'b0); send_payload(32'h0, 1'b0, 1'b0);
        send_byte(SYNC, 1'b0); send_payload(32'h0, 1'b0, 1'b0);
        send_byte(SYNC, 1'b0);
        n_checks++; if (bus.frame_lock !== 1'b1) begin n_fail++; $display("FAIL fh_relock: got %b expected 1", bus.frame_lock); end
    endtask

    task automatic test_flywheel();
        do_reset();
        lock_up();
        for (int k = 0; k < 2; k++) begin
            send_byte(BAD, 1'b0);
            n_checks++; if (bus.sync_miss !== 1'b1)  begin n_fail++; $display("FAIL fly_miss%0d: got %b expected 1", k, bus.sync_miss); end
            n_checks++; if (bus.frame_lock !== 1'b1) begin n_fail++; $display("FAIL fly_hold%0d: got %b expected 1", k, bus.frame_lock); end
            send_payload(PAY, 1'b0, 1'b1);
        end
        send_byte(SYNC, 1'b0);
        n_checks++; if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL fly_recover: got %b expected 1", bus.frame_start); end
        send_payload(PAY, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            send_byte(BAD, 1'b0);
            n_checks++; if (bus.sync_miss !== 1'b1) begin n_fail++; $display("FAIL fly_loss_miss%0d: got %b expected 1", k, bus.sync_miss); end
            n_checks++;
            if (bus.frame_lock !== logic'(k < 2)) begin
                n_fail++; $display("FAIL fly_loss_lock%0d: got %b expected %b", k, bus.frame_lock, k < 2);
            end
            send_payload(PAY, 1'b0, k < 2);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lock_up();
        send_byte(SYNC, 1'b0);
        exp_bytes.push_back(8'h11);
        send_byte(8'h11, 1'b0);
        for (int i = 7; i >= 3; i--) send_bit(PAY[16 + i], 1'b0);
        @(negedge clk);
        rst           = 1'b1;
        bus.enable    = 1'b1;
        bus.serial_in = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (bus.frame_lock !== 1'b0) begin n_fail++; $display("FAIL mid_lock: got %b expected 0", bus.frame_lock); end
        n_checks++; if (bus.byte_out !== 8'h00)  begin n_fail++; $display("FAIL mid_byte: got %h expected 00", bus.byte_out); end
        n_checks++; if (bus.byte_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", bus.byte_valid); end
        @(negedge clk);
        rst        = 1'b0;
        bus.enable = 1'b0;
        send_byte(SYNC, 1'b0); send_payload(PAY, 1'b0, 1'b0);
        send_byte(SYNC, 1'b0);
        n_checks++; if (bus.frame_lock !== 1'b0) begin n_fail++; $display("FAIL mid_relock_early: got %b expected 0", bus.frame_lock); end
        send_payload(PAY, 1'b0, 1'b0);
        send_byte(SYNC, 1'b0);
        n_checks++; if (bus.frame_lock !== 1'b1) begin n_fail++; $display("FAIL mid_relock: got %b expected 1", bus.frame_lock); end
        send_payload(PAY, 1'b0, 1'b1);
    endtask

`ifdef SYNC_ERR_CNT_EN
    task automatic false_hit_miss();
        send_byte(SYNC, 1'b0); send_payload(32'h0, 1'b0, 1'b0); send_byte(8'h00, 1'b0);
    endtask

    task automatic test_err_cnt();
        do_reset();
        for (int k = 0; k < 5; k++) false_hit_miss();
        n_checks++; if (bus.sync_err_cnt !== 16'd5) begin n_fail++; $display("FAIL errcnt_five: got %0d expected 5", bus.sync_err_cnt); end
        @(negedge clk);
        force dut.err_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.err_cnt_q;
        false_hit_miss();
        n_checks++; if (bus.sync_err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL errcnt_top: got %h expected FFFF", bus.sync_err_cnt); end
        false_hit_miss();
        n_checks++; if (bus.sync_err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL errcnt_sat: got %h expected FFFF", bus.sync_err_cnt); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable    = 1'b0;
        bus.serial_in = 1'b0;
        rst           = 1'b1;
        test_reset();
        test_clean_lock(1'b0, "clean");
        test_false_hit();
        test_flywheel();
        test_clean_lock(1'b1, "gapped");
        test_reset_mid();
`ifdef SYNC_ERR_CNT_EN
        test_err_cnt();
`endif
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (exp_bytes.size() != 0) begin
            n_fail++; $display("FAIL queue_empty: %0d bytes never delivered, expected 0", exp_bytes.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
